// File: rtl/music_pkg.sv
// Shared constants for the music ROM sequencer: note word fields, FSM encoding
// and the tone half-period table for a 50 MHz clock.
package music_pkg;

  localparam int unsigned DUR_W     = 4;
  localparam int unsigned PITCH_W   = 6;
  localparam int unsigned HP_W      = 17;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned NUM_NOTES = 36;

  localparam int unsigned DUR_MSB   = 11;
  localparam int unsigned DUR_LSB   = 8;
  localparam int unsigned PITCH_MSB = 5;
  localparam int unsigned PITCH_LSB = 0;

  localparam logic [11:0] END_MARKER = 12'h000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // round(50e6 / (2 * f)) for C4..B6, equal temperament with A4 = 440 Hz
  localparam logic [HP_W-1:0] HALF_PERIOD [0:NUM_NOTES] = '{
    17'd0,
    17'd95556, 17'd90193, 17'd85131, 17'd80353, 17'd75843, 17'd71586,
    17'd67569, 17'd63776, 17'd60197, 17'd56818, 17'd53629, 17'd50619,
    17'd47778, 17'd45097, 17'd42566, 17'd40177, 17'd37922, 17'd35793,
    17'd33784, 17'd31888, 17'd30098, 17'd28409, 17'd26815, 17'd25310,
    17'd23889, 17'd22548, 17'd21283, 17'd20088, 17'd18961, 17'd17897,
    17'd16892, 17'd15944, 17'd15049, 17'd14205, 17'd13407, 17'd12655
  };

  // Pitches above the table are rests and map to a zero half period.
  function automatic logic [HP_W-1:0] half_period_of(input logic [PITCH_W-1:0] pitch);
    logic [HP_W-1:0] hp;
    if (pitch > PITCH_W'(NUM_NOTES)) hp = '0;
    else                             hp = HALF_PERIOD[pitch];
    return hp;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles buzzer_o every half_period_i enabled cycles,
// and clears counter and output whenever it is not enabled.
module tone_gen
  import music_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period_i,
  output logic            buzzer_o
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            buzz_q, buzz_d;

  always_comb begin
    cnt_d  = '0;
    buzz_d = 1'b0;
    if (enable && (half_period_i != '0)) begin
      if (cnt_q == half_period_i - HP_W'(1)) begin
        cnt_d  = '0;
        buzz_d = ~buzz_q;
      end else begin
        cnt_d  = cnt_q + HP_W'(1);
        buzz_d = buzz_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      buzz_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      buzz_q <= buzz_d;
    end
  end

  assign buzzer_o = buzz_q;

endmodule

// File: rtl/music_sequencer.sv
// Music ROM playback controller: fetches 12-bit note words, times each note in
// beats, inserts an articulation gap and drives the speaker square wave.
module music_sequencer
  import music_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned BEAT_CYCLES = 3125000,
  parameter int unsigned GAP_CYCLES  = 250000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy,
  output logic [5:0]            note_o,
  output logic                  buzzer_o,
  output logic                  done
);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DUR_W-1:0]      dur_q, dur_d;
  logic [DUR_W-1:0]      beat_q, beat_d;
  logic [PITCH_W-1:0]    pitch_q, pitch_d;
  logic [CNT_W-1:0]      cyc_q, cyc_d;
  logic                  loop_q, loop_d;
  logic                  rom_en_q, busy_q, done_q;
  logic [PITCH_W-1:0]    note_q, note_d;
  logic                  advance, audible_d;
  logic                  tone_en_c;
  logic [HP_W-1:0]       hp_c;
  logic                  unused_rsvd;

  assign unused_rsvd = ^rom_data[7:6];

  // Next-state logic; cyc_q times beats in PLAY and the gap in GAP.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dur_d   = dur_q;
    beat_d  = beat_q;
    pitch_d = pitch_q;
    cyc_d   = cyc_q;
    loop_d  = loop_q;
    advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        dur_d   = rom_data[DUR_MSB:DUR_LSB];
        pitch_d = rom_data[PITCH_MSB:PITCH_LSB];
        loop_d  = loop_en;
        beat_d  = '0;
        cyc_d   = '0;
        if (rom_data[DUR_MSB:DUR_LSB] == END_MARKER[DUR_MSB:DUR_LSB]) begin
          if (loop_en) begin
            state_d = ST_FETCH;
            addr_d  = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (cyc_q == CNT_W'(BEAT_CYCLES - 1)) begin
          cyc_d = '0;
          if (beat_q == dur_q - DUR_W'(1)) begin
            if (GAP_CYCLES == 0) advance = 1'b1;
            else                 state_d = ST_GAP;
          end else begin
            beat_d = beat_q + DUR_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cyc_q == CNT_W'(GAP_CYCLES - 1)) advance = 1'b1;
        else                                 cyc_d   = cyc_q + CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Running off the top of the address space ends the song like a marker.
    if (advance) begin
      if (addr_q == '1) begin
        if (loop_q) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        state_d = ST_FETCH;
        addr_d  = addr_q + ADDR_WIDTH'(1);
      end
    end

    if (stop) state_d = ST_IDLE;
  end

  assign audible_d = (pitch_d != '0) && (pitch_d <= PITCH_W'(NUM_NOTES));
  assign note_d    = ((state_d == ST_PLAY) && audible_d) ? pitch_d : '0;

  // Tone runs only while staying in PLAY, so it restarts cleared on each entry.
  assign tone_en_c = (state_q == ST_PLAY) && (state_d == ST_PLAY);
  assign hp_c      = half_period_of(pitch_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      dur_q    <= '0;
      beat_q   <= '0;
      pitch_q  <= '0;
      cyc_q    <= '0;
      loop_q   <= 1'b0;
      rom_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      note_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dur_q    <= dur_d;
      beat_q   <= beat_d;
      pitch_q  <= pitch_d;
      cyc_q    <= cyc_d;
      loop_q   <= loop_d;
      rom_en_q <= (state_d == ST_FETCH);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      note_q   <= note_d;
    end
  end

  tone_gen u_tone (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (tone_en_c),
    .half_period_i (hp_c),
    .buzzer_o      (buzzer_o)
  );

  assign rom_en   = rom_en_q;
  assign rom_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_o   = note_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: random songs against an event-list song model,
// plus directed stop, reset, wrap and tone-period cases on three instances.
module tb_music_sequencer;

  localparam int BEAT      = 8;
  localparam int GAP_B     = 4;
  localparam int TONE_BEAT = 3790;
  localparam int HP_A4     = 56818;

  typedef struct {
    int en; int busy; int done; int note; int buz; int addr; int chk;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a = 1'b0, rst_n_bt = 1'b0;
  logic        start_a = 1'b0, stop_a = 1'b0, loop_a = 1'b0;
  logic        start_b = 1'b0, stop_b = 1'b0, loop_b = 1'b0;
  logic        start_t = 1'b0, stop_t = 1'b0, loop_t = 1'b0;
  logic        rom_en_a, rom_en_b, rom_en_t;
  logic [15:0] rom_addr_a, rom_addr_t;
  logic [1:0]  rom_addr_b;
  logic [11:0] rom_data_a = '0, rom_data_b = '0, rom_data_t = '0;
  logic        busy_a, busy_b, busy_t, buzzer_a, buzzer_b, buzzer_t;
  logic        done_a, done_b, done_t;
  logic [5:0]  note_a, note_b, note_t;

  logic [11:0] song  [0:255];
  logic [11:0] rom_a [0:255];
  logic [11:0] rom_b [0:3];
  cyc_t        exp_q [$];
  int          n_checks = 0, n_errors = 0;

  music_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(12), .BEAT_CYCLES(BEAT), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .stop(stop_a), .loop_en(loop_a),
    .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a), .busy(busy_a),
    .note_o(note_a), .buzzer_o(buzzer_a), .done(done_a));

  music_sequencer #(.ADDR_WIDTH(2), .DATA_WIDTH(12), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP_B)) u_b (
    .clk(clk), .rst_n(rst_n_bt), .start(start_b), .stop(stop_b), .loop_en(loop_b),
    .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b), .busy(busy_b),
    .note_o(note_b), .buzzer_o(buzzer_b), .done(done_b));

  music_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(12), .BEAT_CYCLES(TONE_BEAT), .GAP_CYCLES(0)) u_t (
    .clk(clk), .rst_n(rst_n_bt), .start(start_t), .stop(stop_t), .loop_en(loop_t),
    .rom_en(rom_en_t), .rom_addr(rom_addr_t), .rom_data(rom_data_t), .busy(busy_t),
    .note_o(note_t), .buzzer_o(buzzer_t), .done(done_t));

  // Registered-read ROMs, one cycle of latency.
  always @(posedge clk) begin
    if (rom_en_a) rom_data_a <= (rom_addr_a < 16'd256) ? rom_a[rom_addr_a[7:0]] : 12'h000;
    if (rom_en_b) rom_data_b <= rom_b[rom_addr_b];
    if (rom_en_t) rom_data_t <= (rom_addr_t == 16'd0) ? 12'hF0A : 12'h000;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rand_song(input int n);
    for (int i = 0; i < 256; i++) song[i] = 12'h000;
    for (int i = 0; i < n; i++)
      song[i] = 12'(($urandom_range(1, 15) << 8) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63));
    song[n] = 12'($urandom_range(0, 255));
  endtask

  task automatic load_roms();
    for (int i = 0; i < 256; i++) rom_a[i] = song[i];
    for (int i = 0; i < 4; i++) rom_b[i] = song[i];
  endtask

  // Expected per-cycle trace after the start edge, built note by note from the song.
  // Buzzer is always 0 here: the shortest half period outlasts the longest note at BEAT=8.
  task automatic model(input int gap, input int amax, input bit loop, input int ncyc);
    cyc_t e, idle;
    int a, w, d, p, end_len;
    idle = '{0, 0, 0, 0, 0, 0, 0};
    exp_q.delete();
    a = 0;
    end_len = -1;
    while (exp_q.size() < ncyc) begin
      e = '{1, 1, 0, 0, 0, a, 1};
      exp_q.push_back(e);
      e.en = 0;
      exp_q.push_back(e);
      w = (a < 256) ? int'(song[a]) : 0;
      d = (w >> 8) & 15;
      p = w & 63;
      e.chk = 0;
      if (d == 0) begin
        if (loop) begin a = 0; continue; end
        e.done = 1; exp_q.push_back(e); end_len = exp_q.size(); break;
      end
      e.note = (p >= 1 && p <= 36) ? p : 0;
      repeat (d * BEAT) exp_q.push_back(e);
      e.note = 0;
      repeat (gap) exp_q.push_back(e);
      if (a == amax) begin
        if (loop) begin a = 0; continue; end
        e.done = 1; exp_q.push_back(e); end_len = exp_q.size(); break;
      end
      a++;
    end
    while (exp_q.size() < ncyc) exp_q.push_back(idle);
    if (end_len >= 0) while (exp_q.size() > end_len + 3) void'(exp_q.pop_back());
    while (exp_q.size() > ncyc) void'(exp_q.pop_back());
  endtask

  task automatic apply_stop(input int s);
    cyc_t idle;
    idle = '{0, 0, 0, 0, 0, 0, 0};
    for (int i = s; i < exp_q.size(); i++) exp_q[i] = idle;
  endtask

  task automatic drive(input int inst, input logic st, input logic sp);
    if (inst == 0) begin start_a = st; stop_a = sp; end
    else           begin start_b = st; stop_b = sp; end
  endtask

  task automatic run(input int inst, input string name, input int start_at, input int stop_at);
    cyc_t o;
    @(negedge clk); drive(inst, 1'b1, 1'b0);
    @(negedge clk); drive(inst, 1'b0, 1'b0);
    for (int c = 1; c <= exp_q.size(); c++) begin
      if (inst == 0) o = '{int'(rom_en_a), int'(busy_a), int'(done_a), int'(note_a), int'(buzzer_a), int'(rom_addr_a), 0};
      else           o = '{int'(rom_en_b), int'(busy_b), int'(done_b), int'(note_b), int'(buzzer_b), int'(rom_addr_b), 0};
      check_eq($sformatf("%s c%0d rom_en", name, c), o.en, exp_q[c-1].en);
      check_eq($sformatf("%s c%0d busy", name, c), o.busy, exp_q[c-1].busy);
      check_eq($sformatf("%s c%0d done", name, c), o.done, exp_q[c-1].done);
      check_eq($sformatf("%s c%0d note", name, c), o.note, exp_q[c-1].note);
      check_eq($sformatf("%s c%0d buzzer", name, c), o.buz, exp_q[c-1].buz);
      if (exp_q[c-1].chk != 0) check_eq($sformatf("%s c%0d rom_addr", name, c), o.addr, exp_q[c-1].addr);
      drive(inst, c == start_at, c == stop_at);
      @(negedge clk);
    end
    drive(inst, 1'b0, 1'b0);
  endtask

  // Long A4 note on its own instance: first rising edge 56818 cycles after PLAY entry (cycle 3).
  task automatic tone_test();
    int first_hi, fall, changes, last_c;
    logic prev;
    first_hi = 0; fall = 0; changes = 0; prev = 1'b0;
    last_c = 3 + 15 * TONE_BEAT + 2;
    @(negedge clk); start_t = 1'b1;
    @(negedge clk); start_t = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      if (c == 3) check_eq("tone note", int'(note_t), 10);
      if (buzzer_t != prev) begin
        changes++;
        if (buzzer_t && first_hi == 0) first_hi = c;
        if (!buzzer_t) fall = c;
      end
      prev = buzzer_t;
      @(negedge clk);
    end
    check_eq("tone first edge", first_hi, 3 + HP_A4);
    check_eq("tone fall at note end", fall, 3 + 15 * TONE_BEAT);
    check_eq("tone edge count", changes, 2);
  endtask

  task automatic main_tests();
    int n, s;
    // single note, end marker
    rand_song(0); song[0] = 12'h10A; song[1] = 12'h000; load_roms();
    model(0, 65535, 1'b0, 5000); run(0, "single", 0, 0);
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 8); rand_song(n); load_roms();
      model(0, 65535, 1'b0, 5000); run(0, $sformatf("rand%0d", k), 5, 0);
    end
    // loop: two notes then marker
    rand_song(0); song[0] = 12'h10A; song[1] = 12'h205; song[2] = 12'h000; load_roms();
    loop_a = 1'b1; model(0, 65535, 1'b1, 80); apply_stop(77); run(0, "loop", 0, 77);
    for (int k = 0; k < 2; k++) begin
      n = $urandom_range(1, 3); rand_song(n); load_roms();
      s = $urandom_range(20, 296);
      model(0, 65535, 1'b1, 300); apply_stop(s); run(0, $sformatf("rloop%0d", k), 0, s);
    end
    loop_a = 1'b0;
    // stop on the 5th PLAY cycle
    rand_song(0); song[0] = 12'h30A; song[1] = 12'h000; load_roms();
    model(0, 65535, 1'b0, 12); apply_stop(7); run(0, "stop", 0, 7);
    // start and stop together leave it idle
    @(negedge clk); start_a = 1'b1; stop_a = 1'b1;
    @(negedge clk); start_a = 1'b0; stop_a = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_eq($sformatf("startstop c%0d busy", c), int'(busy_a), 0);
      check_eq($sformatf("startstop c%0d rom_en", c), int'(rom_en_a), 0);
      @(negedge clk);
    end
    // asynchronous reset mid-PLAY
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("areset pre note", int'(note_a), 10);
    check_eq("areset pre busy", int'(busy_a), 1);
    #2 rst_n_a = 1'b0;
    #1;
    check_eq("areset busy", int'(busy_a), 0);
    check_eq("areset note", int'(note_a), 0);
    check_eq("areset rom_en", int'(rom_en_a), 0);
    check_eq("areset rom_addr", int'(rom_addr_a), 0);
    check_eq("areset buzzer", int'(buzzer_a), 0);
    check_eq("areset done", int'(done_a), 0);
    #1 rst_n_a = 1'b1;
    @(negedge clk);
    check_eq("areset after busy", int'(busy_a), 0);
    // rest with gap, address wrap, wrap with looping
    rand_song(0); song[0] = 12'h200; song[1] = 12'h000; load_roms();
    model(GAP_B, 3, 1'b0, 5000); run(1, "restgap", 0, 0);
    rand_song(4); load_roms();
    model(GAP_B, 3, 1'b0, 5000); run(1, "wrap", 0, 0);
    loop_b = 1'b1; model(GAP_B, 3, 1'b1, 300); apply_stop(290); run(1, "wraploop", 0, 290);
    loop_b = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset busy", int'(busy_a), 0);
    check_eq("reset note", int'(note_a), 0);
    check_eq("reset rom_en", int'(rom_en_a), 0);
    check_eq("reset rom_addr", int'(rom_addr_a), 0);
    check_eq("reset buzzer", int'(buzzer_a), 0);
    check_eq("reset done", int'(done_a), 0);
    check_eq("reset b busy", int'(busy_b), 0);
    check_eq("reset b rom_en", int'(rom_en_b), 0);
    check_eq("reset t busy", int'(busy_t), 0);
    rst_n_a = 1'b1;
    rst_n_bt = 1'b1;
    @(negedge clk);
    check_eq("post reset busy", int'(busy_a), 0);
    fork
      tone_test();
      main_tests();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
